// File: rtl/jogo_pkg.sv
// jogo_pkg: shared widths and state encoding for the note-memory round controller
package jogo_pkg;
  localparam int TAM_NOTA = 7;
  localparam int TAM_END = 4;
  localparam int TAM_MUSICA = 3;
  typedef enum logic [3:0] {
    OCIOSO, PAUSA, LE_M, MOSTRA, INTERVALO, LE_J, ESPERA, COMPARA, FIM_ACERTO, FIM_ERRO
  } estado_t;
endpackage

// File: rtl/detector_pressao.sv
// detector_pressao: flags the cycle buttons leave the all-released state and captures the pressed value
module detector_pressao
  import jogo_pkg::*;
(
  input  logic                clock,
  input  logic                reset_n,
  input  logic [TAM_NOTA-1:0] botoes,
  output logic                pressao,
  output logic [TAM_NOTA-1:0] valor
);
  logic [TAM_NOTA-1:0] botoes_q;
  assign pressao = botoes_q == '0 && botoes != '0;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      botoes_q <= '0;
      valor <= '0;
    end else begin
      botoes_q <= botoes;
      if (pressao) valor <= botoes;
    end
endmodule

// File: rtl/verificador_jogada.sv
// verificador_jogada: plays each round's note sequence from memory, then checks the player's presses against it
module verificador_jogada
  import jogo_pkg::*;
#(
  parameter int TEMPO_NOTA = 25_000_000,
  parameter int TEMPO_PAUSA = 12_500_000,
  parameter int TEMPO_JOGADA = 250_000_000,
  parameter logic [TAM_END-1:0] ULTIMA_RODADA = 4'd15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  iniciar,
  input  logic [TAM_MUSICA-1:0] musica_in,
  input  logic [TAM_NOTA-1:0]   botoes,
  input  logic [TAM_NOTA-1:0]   nota_memoria,
  output logic [TAM_END-1:0]    endereco,
  output logic [TAM_MUSICA-1:0] select_musica,
  output logic [TAM_NOTA-1:0]   tocar_nota,
  output logic [TAM_END-1:0]    rodada,
  output logic                  em_jogada,
  output logic                  acertou,
  output logic                  errou
);
  localparam int TMAX = TEMPO_JOGADA > TEMPO_NOTA
    ? (TEMPO_JOGADA > TEMPO_PAUSA ? TEMPO_JOGADA : TEMPO_PAUSA)
    : (TEMPO_NOTA > TEMPO_PAUSA ? TEMPO_NOTA : TEMPO_PAUSA);
  localparam int TW = $clog2(TMAX) + 1;
  estado_t estado, estado_n;
  logic [TW-1:0] timer;
  logic [TAM_END-1:0] endereco_n, rodada_n;
  logic [TAM_MUSICA-1:0] select_n;
  logic pressao, pausa_fim;
  logic [TAM_NOTA-1:0] valor;
  detector_pressao u_detector (
    .clock(clock),
    .reset_n(reset_n),
    .botoes(botoes),
    .pressao(pressao),
    .valor(valor)
  );
  assign pausa_fim = timer == TW'(TEMPO_PAUSA - 1);
  always_comb begin
    estado_n = estado;
    endereco_n = endereco;
    rodada_n = rodada;
    select_n = select_musica;
    case (estado)
      OCIOSO, FIM_ACERTO, FIM_ERRO:
        if (iniciar) begin
          estado_n = PAUSA;
          select_n = musica_in;
          rodada_n = '0;
          endereco_n = '0;
        end
      PAUSA:
        if (pausa_fim) begin
          estado_n = LE_M;
          endereco_n = '0;
        end
      LE_M: estado_n = MOSTRA;
      // one extra cycle here: the registered ROM word only reaches tocar_nota a cycle after MOSTRA begins
      MOSTRA: estado_n = timer == TW'(TEMPO_NOTA) ? INTERVALO : MOSTRA;
      INTERVALO:
        if (pausa_fim) begin
          estado_n = endereco == rodada ? LE_J : LE_M;
          endereco_n = endereco == rodada ? '0 : endereco + 4'd1;
        end
      LE_J: estado_n = ESPERA;
      ESPERA: estado_n = pressao ? COMPARA : timer == TW'(TEMPO_JOGADA - 1) ? FIM_ERRO : ESPERA;
      COMPARA:
        if (valor != nota_memoria) estado_n = FIM_ERRO;
        else if (endereco < rodada) begin
          estado_n = LE_J;
          endereco_n = endereco + 4'd1;
        end else if (rodada < ULTIMA_RODADA) begin
          estado_n = PAUSA;
          rodada_n = rodada + 4'd1;
        end else estado_n = FIM_ACERTO;
      default: estado_n = OCIOSO;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      estado <= OCIOSO;
      endereco <= '0;
      rodada <= '0;
      select_musica <= '0;
      tocar_nota <= '0;
      timer <= '0;
      em_jogada <= 1'b0;
      acertou <= 1'b0;
      errou <= 1'b0;
    end else begin
      estado <= estado_n;
      endereco <= endereco_n;
      rodada <= rodada_n;
      select_musica <= select_n;
      timer <= estado_n != estado ? '0 : &timer ? timer : timer + 1'b1;
      tocar_nota <= estado == MOSTRA && estado_n == MOSTRA ? nota_memoria : '0;
      em_jogada <= estado_n inside {ESPERA, COMPARA};
      acertou <= estado_n == FIM_ACERTO;
      errou <= estado_n == FIM_ERRO;
    end
endmodule
